sha_result_checker: RTL and testbench

//  Consumes the double-SHA256 result stream of the last pipelined core
//  (output_valid, newblock_o, doublehash) and checks each hash against a

---
 rtl/sha_result_checker_if.sv | 30 +++
 rtl/sha_result_checker.sv | 115 +++++++++++
 tb/tb_sha_result_checker.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/sha_result_checker_if.sv
// sha_result_checker_if: result stream from the SHA core and hit FIFO head toward the host.
// result_hash exists only with SHA_RESULT_STORE_HASH_EN defined.
interface sha_result_checker_if #(
  parameter int EPOCH_W = 8
);
  logic               in_valid;
  logic               in_newblock;
  logic [255:0]       in_hash;
  logic               result_valid;
  logic               result_ready;
  logic [31:0]        result_nonce;
  logic [EPOCH_W-1:0] result_epoch;
`ifdef SHA_RESULT_STORE_HASH_EN
  logic [255:0]       result_hash;
`endif
  modport master (
    output in_valid, in_newblock, in_hash, result_ready,
    input  result_valid, result_nonce, result_epoch
`ifdef SHA_RESULT_STORE_HASH_EN
    , result_hash
`endif
  );
  modport slave (
    input  in_valid, in_newblock, in_hash, result_ready,
    output result_valid, result_nonce, result_epoch
`ifdef SHA_RESULT_STORE_HASH_EN
    , result_hash
`endif
  );
endinterface

// File: rtl/sha_result_checker.sv
// sha_result_checker: difficulty check, nonce/epoch tagging and hit FIFO for a double-SHA256 stream.
// Define SHA_RESULT_STORE_HASH_EN to store the hash per entry and drive result_hash.
module sha_result_checker #(
  parameter int DEPTH   = 4,
  parameter int EPOCH_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  sha_result_checker_if.slave bus,
  input  logic [7:0]          difficulty,
  output logic                overflow,
  output logic                nonce_wrap,
  output logic [31:0]         hit_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [255:0]       v;
  logic               hit, head_valid, pop, push;
  logic [31:0]        nonce_q, nonce_d, s1_nonce_q, s1_nonce_d, hit_count_q, hit_count_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d, s1_epoch_q, s1_epoch_d;
  logic               s1_valid_q, s1_valid_d, overflow_q, overflow_d, nonce_wrap_q, nonce_wrap_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic [31:0]        nonce_mem_q [DEPTH];
  logic [31:0]        nonce_mem_d [DEPTH];
  logic [EPOCH_W-1:0] epoch_mem_q [DEPTH];
  logic [EPOCH_W-1:0] epoch_mem_d [DEPTH];
`ifdef SHA_RESULT_STORE_HASH_EN
  logic [255:0]       s1_hash_q, s1_hash_d;
  logic [255:0]       hash_mem_q [DEPTH];
  logic [255:0]       hash_mem_d [DEPTH];
`endif
  // Byte-swapping each word and reversing word order is a full byte reversal.
  for (genvar i = 0; i < 32; i++) begin : g_rev
    assign v[8*i +: 8] = bus.in_hash[8*(31-i) +: 8];
  end
  always_comb begin
    hit          = (v & ~({256{1'b1}} >> difficulty)) == '0;
    nonce_d      = bus.in_valid ? (bus.in_newblock ? '0 : nonce_q + 32'd1) : nonce_q;
    epoch_d      = (bus.in_valid && bus.in_newblock) ? epoch_q + EPOCH_W'(1) : epoch_q;
    nonce_wrap_d = nonce_wrap_q | (bus.in_valid & ~bus.in_newblock & (&nonce_q));
    s1_valid_d   = bus.in_valid & hit;
    s1_nonce_d   = nonce_d;
    s1_epoch_d   = epoch_d;
`ifdef SHA_RESULT_STORE_HASH_EN
    s1_hash_d    = bus.in_hash;
`endif
    head_valid   = count_q != '0;
    pop          = head_valid & bus.result_ready;
    push         = s1_valid_q & ((count_q != FULL) | pop);
    overflow_d   = overflow_q | (s1_valid_q & (count_q == FULL) & ~pop);
    hit_count_d  = (push && !(&hit_count_q)) ? hit_count_q + 32'd1 : hit_count_q;
    count_d      = count_q + (AW+1)'(push) - (AW+1)'(pop);
    wr_ptr_d     = wr_ptr_q + AW'(push);
    rd_ptr_d     = rd_ptr_q + AW'(pop);
    nonce_mem_d  = nonce_mem_q;
    epoch_mem_d  = epoch_mem_q;
    if (push) begin
      nonce_mem_d[wr_ptr_q] = s1_nonce_q;
      epoch_mem_d[wr_ptr_q] = s1_epoch_q;
    end
`ifdef SHA_RESULT_STORE_HASH_EN
    hash_mem_d   = hash_mem_q;
    if (push) hash_mem_d[wr_ptr_q] = s1_hash_q;
`endif
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nonce_q      <= '0;
      epoch_q      <= '0;
      nonce_wrap_q <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_nonce_q   <= '0;
      s1_epoch_q   <= '0;
      overflow_q   <= 1'b0;
      hit_count_q  <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      nonce_mem_q  <= '{default: '0};
      epoch_mem_q  <= '{default: '0};
`ifdef SHA_RESULT_STORE_HASH_EN
      s1_hash_q    <= '0;
      hash_mem_q   <= '{default: '0};
`endif
    end else begin
      nonce_q      <= nonce_d;
      epoch_q      <= epoch_d;
      nonce_wrap_q <= nonce_wrap_d;
      s1_valid_q   <= s1_valid_d;
      s1_nonce_q   <= s1_nonce_d;
      s1_epoch_q   <= s1_epoch_d;
      overflow_q   <= overflow_d;
      hit_count_q  <= hit_count_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      nonce_mem_q  <= nonce_mem_d;
      epoch_mem_q  <= epoch_mem_d;
`ifdef SHA_RESULT_STORE_HASH_EN
      s1_hash_q    <= s1_hash_d;
      hash_mem_q   <= hash_mem_d;
`endif
    end
  end
  assign bus.result_valid = head_valid;
  assign bus.result_nonce = head_valid ? nonce_mem_q[rd_ptr_q] : '0;
  assign bus.result_epoch = head_valid ? epoch_mem_q[rd_ptr_q] : '0;
`ifdef SHA_RESULT_STORE_HASH_EN
  assign bus.result_hash  = head_valid ? hash_mem_q[rd_ptr_q] : '0;
`endif
  assign overflow   = overflow_q;
  assign nonce_wrap = nonce_wrap_q;
  assign hit_count  = hit_count_q;
endmodule

// File: tb/tb_sha_result_checker.sv
// tb_sha_result_checker: queue-based reference model checked every cycle, plus directed literal pins.
module tb_sha_result_checker;
  localparam int DEPTH = 4;
  localparam int EPOCH_W = 8;
  localparam logic [255:0] HNZ = {8{32'h11111111}};
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] difficulty = 8'd0;
  logic overflow, nonce_wrap;
  logic [31:0] hit_count;
  int n_checks = 0;
  int n_pass = 0;
  sha_result_checker_if #(.EPOCH_W(EPOCH_W)) bus();
  sha_result_checker #(.DEPTH(DEPTH), .EPOCH_W(EPOCH_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .difficulty(difficulty),
    .overflow(overflow), .nonce_wrap(nonce_wrap), .hit_count(hit_count)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0]        nonce;
    logic [EPOCH_W-1:0] epoch;
    logic [255:0]       hash;
  } entry_t;
  entry_t q[$];
  entry_t s1;
  bit s1_hit = 1'b0;
  bit m_pop = 1'b0;
  bit m_ovf = 1'b0;
  bit m_wrap = 1'b0;
  logic [31:0] m_nonce = '0;
  logic [31:0] m_hits = '0;
  logic [EPOCH_W-1:0] m_epoch = '0;
  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  function automatic bit is_hit(logic [255:0] h, logic [7:0] d);
    logic [255:0] v;
    logic [31:0] w;
    int lz;
    for (int k = 0; k < 8; k++) begin
      w = h[32*k +: 32];
      v[255-32*k -: 32] = {w[7:0], w[15:8], w[23:16], w[31:24]};
    end
    lz = 0;
    for (int b = 255; b >= 0 && !v[b]; b--) lz++;
    return lz >= int'(d);
  endfunction
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      q.delete();
      s1_hit = 1'b0; m_nonce = '0; m_epoch = '0; m_hits = '0; m_ovf = 1'b0; m_wrap = 1'b0;
    end else begin
      m_pop = q.size() != 0 && bus.result_ready;
      if (s1_hit) begin
        if (q.size() < DEPTH || m_pop) begin
          q.push_back(s1);
          if (m_hits != 32'hFFFFFFFF) m_hits = m_hits + 1;
        end else m_ovf = 1'b1;
      end
      if (m_pop) void'(q.pop_front());
      s1_hit = 1'b0;
      if (bus.in_valid) begin
        if (bus.in_newblock) begin
          m_nonce = '0;
          m_epoch = m_epoch + 1'b1;
        end else begin
          if (m_nonce == 32'hFFFFFFFF) m_wrap = 1'b1;
          m_nonce = m_nonce + 1;
        end
        s1_hit = is_hit(bus.in_hash, difficulty);
        s1 = '{m_nonce, m_epoch, bus.in_hash};
      end
    end
  end
  initial forever begin
    @(negedge clk);
    check("result_valid", bus.result_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("result_nonce", bus.result_nonce, q[0].nonce);
      check("result_epoch", bus.result_epoch, q[0].epoch);
`ifdef SHA_RESULT_STORE_HASH_EN
      check("result_hash", bus.result_hash, q[0].hash);
    end else begin
      check("result_hash_idle", bus.result_hash, '0);
`endif
    end
    check("overflow", overflow, m_ovf);
    check("nonce_wrap", nonce_wrap, m_wrap);
    check("hit_count", hit_count, m_hits);
  end
  task automatic drive(bit v, bit nb, logic [255:0] h, logic [7:0] d);
    @(negedge clk);
    bus.in_valid = v; bus.in_newblock = nb; bus.in_hash = h; difficulty = d;
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.in_newblock = 1'b0; bus.in_hash = '0; bus.result_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", bus.result_valid, 0);
    check("rst_hits", hit_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_wrap", nonce_wrap, 0);
    rst = 1'b1;
    // three results of a new block, first visible two cycles after its valid
    drive(1, 1, HNZ, 0);
    drive(1, 0, HNZ, 0); check("t1_latency", bus.result_valid, 0);
    drive(1, 0, HNZ, 0); check("t1_first", {bus.result_valid, bus.result_nonce, bus.result_epoch}, {1'b1, 32'd0, 8'd1});
    drive(0, 0, HNZ, 0); check("t1_second", bus.result_nonce, 1);
    drive(0, 0, HNZ, 0); check("t1_third", bus.result_nonce, 2);
    drive(0, 0, HNZ, 0); check("t1_hits", hit_count, 3); check("t1_empty", bus.result_valid, 0);
    // byte-swap compare order and difficulty boundaries
    drive(1, 0, {{7{32'h11111111}}, 32'h00000000}, 32);
    drive(1, 0, {{7{32'h11111111}}, 32'h01000000}, 32);
    drive(1, 0, {{7{32'h11111111}}, 32'hFF000000}, 8);
    drive(1, 0, {{7{32'h11111111}}, 32'h000000FF}, 8);
    drive(1, 0, {8'h01, 248'h0}, 255); check("t2_swap_hits", hit_count, 5);
    drive(1, 0, {8'h02, 248'h0}, 255);
    repeat (3) drive(0, 0, HNZ, 0);
    bus.result_ready = 1'b0;
    drive(0, 0, HNZ, 0); check("t2_hits", hit_count, 6);
    // full FIFO with a pop in the same cycle as a push
    drive(1, 1, HNZ, 0);
    repeat (4) drive(1, 0, HNZ, 0);
    drive(0, 0, HNZ, 0); check("t4_full_hits", hit_count, 10); check("t4_full_head", bus.result_nonce, 0);
    bus.result_ready = 1'b1;
    drive(0, 0, HNZ, 0);
    check("t4_order", {bus.result_nonce, bus.result_epoch}, {32'd1, 8'd2});
    check("t4_no_ovf", overflow, 0);
    check("t4_hits", hit_count, 11);
    repeat (6) drive(0, 0, HNZ, 0);
    check("t4_drained", bus.result_valid, 0);
    // overflow with no host pops
    bus.result_ready = 1'b0;
    repeat (DEPTH + 2) drive(1, 0, HNZ, 0);
    repeat (3) drive(0, 0, HNZ, 0);
    check("t3_ovf", overflow, 1);
    check("t3_hits", hit_count, 15);
    check("t3_head", bus.result_nonce, 5);
    bus.result_ready = 1'b1;
    repeat (6) drive(0, 0, HNZ, 0);
    // nonce counter preload and wrap
    @(negedge clk);
    force dut.nonce_q = 32'hFFFFFFFE;
    m_nonce = 32'hFFFFFFFE;
    @(negedge clk);
    release dut.nonce_q;
    drive(1, 0, HNZ, 0);
    drive(1, 0, HNZ, 0); check("t5_wrap_pre", nonce_wrap, 0);
    drive(0, 0, HNZ, 0); check("t5_wrap", nonce_wrap, 1); check("t5_head_max", bus.result_nonce, 32'hFFFFFFFF);
    drive(0, 0, HNZ, 0); check("t5_head_zero", bus.result_nonce, 0);
    repeat (3) drive(0, 0, HNZ, 0);
    // asynchronous reset with two queued entries
    bus.result_ready = 1'b0;
    drive(1, 1, HNZ, 0);
    drive(1, 0, HNZ, 0);
    repeat (3) drive(0, 0, HNZ, 0);
    check("t6_two_head", {bus.result_valid, bus.result_nonce, bus.result_epoch}, {1'b1, 32'd0, 8'd3});
    #2 rst = 1'b0;
    #1 check("t6_rst_valid", bus.result_valid, 0);
    check("t6_rst_hits", hit_count, 0);
    check("t6_rst_ovf", overflow, 0);
    check("t6_rst_wrap", nonce_wrap, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 1, HNZ, 0);
    drive(0, 0, HNZ, 0);
    drive(0, 0, HNZ, 0);
    check("t6_restart", {bus.result_valid, bus.result_nonce, bus.result_epoch}, {1'b1, 32'd0, 8'd1});
    repeat (2) drive(0, 0, HNZ, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
